// File: rtl/pmem_arbiter.sv
// pmem_arbiter: shares one line-wide physical-memory port between the
// I-cache (read only) and the D-cache (read/write), one line at a time.
module pmem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 256
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic [ADDR_WIDTH-1:0] i_pmem_address,
    input  logic                  i_pmem_read,
    output logic [LINE_WIDTH-1:0] i_pmem_rdata,
    output logic                  i_pmem_resp,

    input  logic [ADDR_WIDTH-1:0] d_pmem_address,
    input  logic                  d_pmem_read,
    input  logic                  d_pmem_write,
    input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
    output logic [LINE_WIDTH-1:0] d_pmem_rdata,
    output logic                  d_pmem_resp,

    output logic [ADDR_WIDTH-1:0] pmem_address,
    output logic [LINE_WIDTH-1:0] pmem_wdata,
    output logic                  pmem_read,
    output logic                  pmem_write,
    input  logic [LINE_WIDTH-1:0] pmem_rdata,
    input  logic                  pmem_resp
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } state_t;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } grant_t;

    state_t state_q;
    state_t state_d;
    grant_t last_grant_q;
    grant_t last_grant_d;

    logic i_req;
    logic d_req;

    assign i_req = i_pmem_read;
    assign d_req = d_pmem_read | d_pmem_write;

    // State and round-robin history; reset forces IDLE at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= GRANT_I;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Next state: grant in IDLE, hold the grant until the memory responds.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        unique case (state_q)
            IDLE: begin
                if (i_req && d_req) begin
                    // Tie goes to whoever was not served last.
                    if (last_grant_q == GRANT_I) state_d = SERVE_D;
                    else                         state_d = SERVE_I;
                end else if (i_req) begin
                    state_d = SERVE_I;
                end else if (d_req) begin
                    state_d = SERVE_D;
                end
            end
            SERVE_I: begin
                if (pmem_resp) begin
                    state_d      = IDLE;
                    last_grant_d = GRANT_I;
                end
            end
            SERVE_D: begin
                if (pmem_resp) begin
                    state_d      = IDLE;
                    last_grant_d = GRANT_D;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Memory-side strobes and per-requester resp, steered by the grant.
    always_comb begin
        pmem_address = '0;
        pmem_wdata   = '0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        i_pmem_resp  = 1'b0;
        d_pmem_resp  = 1'b0;
        unique case (state_q)
            SERVE_I: begin
                pmem_address = i_pmem_address;
                pmem_read    = i_pmem_read;
                i_pmem_resp  = pmem_resp;
            end
            SERVE_D: begin
                pmem_address = d_pmem_address;
                pmem_wdata   = d_pmem_wdata;
                // A write beats an illegal simultaneous read.
                if (d_pmem_write) begin
                    pmem_write = 1'b1;
                end else begin
                    pmem_read  = d_pmem_read;
                end
                d_pmem_resp  = pmem_resp;
            end
            default: begin
                pmem_address = '0;
            end
        endcase
    end

    // Read data fans out to both caches; only resp qualifies it.
    assign i_pmem_rdata = pmem_rdata;
    assign d_pmem_rdata = pmem_rdata;

endmodule

// File: tb/tb_pmem_arbiter.sv
// tb_pmem_arbiter: directed checks of grant order, strobe steering,
// resp gating and asynchronous reset for pmem_arbiter.
module tb_pmem_arbiter;

    localparam int AW = 32;
    localparam int LW = 256;

    logic          clk;
    logic          rst;
    logic [AW-1:0] i_pmem_address;
    logic          i_pmem_read;
    logic [LW-1:0] i_pmem_rdata;
    logic          i_pmem_resp;
    logic [AW-1:0] d_pmem_address;
    logic          d_pmem_read;
    logic          d_pmem_write;
    logic [LW-1:0] d_pmem_wdata;
    logic [LW-1:0] d_pmem_rdata;
    logic          d_pmem_resp;
    logic [AW-1:0] pmem_address;
    logic [LW-1:0] pmem_wdata;
    logic          pmem_read;
    logic          pmem_write;
    logic [LW-1:0] pmem_rdata;
    logic          pmem_resp;

    int total;
    int passed;
    int failed;

    localparam logic [LW-1:0] PAT_A = {8{32'hA5A5_0001}};
    localparam logic [LW-1:0] PAT_B = {8{32'h5A5A_F00D}};
    localparam logic [LW-1:0] PAT_C = {8{32'h1234_5678}};

    pmem_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
        .clk            (clk),
        .rst            (rst),
        .i_pmem_address (i_pmem_address),
        .i_pmem_read    (i_pmem_read),
        .i_pmem_rdata   (i_pmem_rdata),
        .i_pmem_resp    (i_pmem_resp),
        .d_pmem_address (d_pmem_address),
        .d_pmem_read    (d_pmem_read),
        .d_pmem_write   (d_pmem_write),
        .d_pmem_wdata   (d_pmem_wdata),
        .d_pmem_rdata   (d_pmem_rdata),
        .d_pmem_resp    (d_pmem_resp),
        .pmem_address   (pmem_address),
        .pmem_wdata     (pmem_wdata),
        .pmem_read      (pmem_read),
        .pmem_write     (pmem_write),
        .pmem_rdata     (pmem_rdata),
        .pmem_resp      (pmem_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [LW-1:0] obs,
                       input logic [LW-1:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    initial begin
        logic gseq [4];
        total  = 0;
        passed = 0;
        failed = 0;

        rst            = 1'b1;
        i_pmem_address = '0;
        i_pmem_read    = 1'b0;
        d_pmem_address = 32'hDEAD_0000;
        d_pmem_read    = 1'b0;
        d_pmem_write   = 1'b0;
        d_pmem_wdata   = PAT_C;
        pmem_rdata     = '0;
        pmem_resp      = 1'b0;

        // Reset state: everything low, address/wdata zero.
        step();
        step();
        chk("rst_pmem_read", LW'(pmem_read), LW'(1'b0));
        chk("rst_pmem_write", LW'(pmem_write), LW'(1'b0));
        chk("rst_i_resp", LW'(i_pmem_resp), LW'(1'b0));
        chk("rst_d_resp", LW'(d_pmem_resp), LW'(1'b0));
        chk("rst_addr", LW'(pmem_address), LW'(32'h0));
        chk("rst_wdata", pmem_wdata, '0);
        @(negedge clk);
        rst = 1'b0;
        step();

        // Lone I read.
        i_pmem_address = 32'h0000_0060;
        i_pmem_read    = 1'b1;
        #1;
        chk("i_rd_no_strobe_yet", LW'(pmem_read), LW'(1'b0));
        step();
        chk("i_rd_strobe", LW'(pmem_read), LW'(1'b1));
        chk("i_rd_addr", LW'(pmem_address), LW'(32'h60));
        chk("i_rd_nowrite", LW'(pmem_write), LW'(1'b0));
        step();
        step();
        step();
        chk("i_rd_wait_resp", LW'(i_pmem_resp), LW'(1'b0));
        pmem_resp  = 1'b1;
        pmem_rdata = PAT_A;
        #1;
        chk("i_rd_resp", LW'(i_pmem_resp), LW'(1'b1));
        chk("i_rd_rdata", i_pmem_rdata, PAT_A);
        chk("i_rd_d_resp", LW'(d_pmem_resp), LW'(1'b0));
        chk("i_rd_d_rdata", d_pmem_rdata, PAT_A);
        step();
        pmem_resp   = 1'b0;
        i_pmem_read = 1'b0;
        #1;
        chk("i_rd_idle", LW'(pmem_read), LW'(1'b0));
        chk("i_rd_idle_resp", LW'(i_pmem_resp), LW'(1'b0));

        // Lone D write.
        d_pmem_address = 32'h0000_1000;
        d_pmem_wdata   = PAT_B;
        d_pmem_write   = 1'b1;
        step();
        chk("d_wr_strobe", LW'(pmem_write), LW'(1'b1));
        chk("d_wr_noread", LW'(pmem_read), LW'(1'b0));
        chk("d_wr_addr", LW'(pmem_address), LW'(32'h1000));
        chk("d_wr_wdata", pmem_wdata, PAT_B);
        step();
        chk("d_wr_hold", LW'(pmem_write), LW'(1'b1));
        chk("d_wr_wait_resp", LW'(d_pmem_resp), LW'(1'b0));
        pmem_resp = 1'b1;
        #1;
        chk("d_wr_resp", LW'(d_pmem_resp), LW'(1'b1));
        chk("d_wr_i_resp", LW'(i_pmem_resp), LW'(1'b0));
        step();
        pmem_resp    = 1'b0;
        d_pmem_write = 1'b0;
        #1;
        chk("d_wr_idle", LW'(pmem_write), LW'(1'b0));

        // Simultaneous requests right after reset: D first.
        do_reset();
        i_pmem_address = 32'h40;
        i_pmem_read    = 1'b1;
        d_pmem_address = 32'h80;
        d_pmem_read    = 1'b1;
        step();
        chk("tie_d_addr", LW'(pmem_address), LW'(32'h80));
        chk("tie_d_read", LW'(pmem_read), LW'(1'b1));
        pmem_resp  = 1'b1;
        pmem_rdata = PAT_C;
        #1;
        chk("tie_d_resp", LW'(d_pmem_resp), LW'(1'b1));
        chk("tie_d_i_resp", LW'(i_pmem_resp), LW'(1'b0));
        step();
        pmem_resp   = 1'b0;
        d_pmem_read = 1'b0;
        #1;
        chk("tie_gap", LW'(pmem_read), LW'(1'b0));
        step();
        chk("tie_i_addr", LW'(pmem_address), LW'(32'h40));
        chk("tie_i_read", LW'(pmem_read), LW'(1'b1));
        pmem_resp = 1'b1;
        #1;
        chk("tie_i_resp", LW'(i_pmem_resp), LW'(1'b1));
        chk("tie_i_d_resp", LW'(d_pmem_resp), LW'(1'b0));
        step();
        pmem_resp   = 1'b0;
        i_pmem_read = 1'b0;
        #1;

        // Fairness: both held; last grant was I so D, I, D, I.
        gseq[0] = 1'b1;
        gseq[1] = 1'b0;
        gseq[2] = 1'b1;
        gseq[3] = 1'b0;
        i_pmem_address = 32'h100;
        i_pmem_read    = 1'b1;
        d_pmem_address = 32'h2000;
        d_pmem_wdata   = PAT_B;
        d_pmem_write   = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk($sformatf("fair%0d_addr", k), LW'(pmem_address),
                gseq[k] ? LW'(32'h2000) : LW'(32'h100));
            chk($sformatf("fair%0d_wr", k), LW'(pmem_write),
                LW'(gseq[k]));
            pmem_resp = 1'b1;
            #1;
            chk($sformatf("fair%0d_d_resp", k), LW'(d_pmem_resp),
                LW'(gseq[k]));
            chk($sformatf("fair%0d_i_resp", k), LW'(i_pmem_resp),
                LW'(!gseq[k]));
            step();
            pmem_resp = 1'b0;
            #1;
            chk($sformatf("fair%0d_gap", k),
                LW'(pmem_read | pmem_write), LW'(1'b0));
        end
        i_pmem_read  = 1'b0;
        d_pmem_write = 1'b0;
        step();

        // Illegal D read+write: write wins; then withdrawal before resp.
        d_pmem_address = 32'h3000;
        d_pmem_read    = 1'b1;
        d_pmem_write   = 1'b1;
        step();
        chk("rw_write", LW'(pmem_write), LW'(1'b1));
        chk("rw_noread", LW'(pmem_read), LW'(1'b0));
        d_pmem_read  = 1'b0;
        d_pmem_write = 1'b0;
        #1;
        chk("wd_write_low", LW'(pmem_write), LW'(1'b0));
        step();
        pmem_resp = 1'b1;
        #1;
        chk("wd_still_granted", LW'(d_pmem_resp), LW'(1'b1));
        step();
        pmem_resp = 1'b0;
        #1;

        // Reset in the middle of an I transaction.
        i_pmem_address = 32'h60;
        i_pmem_read    = 1'b1;
        step();
        chk("mid_strobe", LW'(pmem_read), LW'(1'b1));
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_strobe", LW'(pmem_read), LW'(1'b0));
        pmem_resp = 1'b1;
        #1;
        chk("mid_rst_i_resp", LW'(i_pmem_resp), LW'(1'b0));
        chk("mid_rst_d_resp", LW'(d_pmem_resp), LW'(1'b0));
        step();
        chk("mid_held_i_resp", LW'(i_pmem_resp), LW'(1'b0));
        pmem_resp      = 1'b0;
        d_pmem_address = 32'h80;
        d_pmem_read    = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        step();
        chk("post_rst_d_wins", LW'(pmem_address), LW'(32'h80));
        chk("post_rst_read", LW'(pmem_read), LW'(1'b1));
        pmem_resp = 1'b1;
        #1;
        chk("post_rst_d_resp", LW'(d_pmem_resp), LW'(1'b1));
        step();
        pmem_resp   = 1'b0;
        d_pmem_read = 1'b0;
        i_pmem_read = 1'b0;
        step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
